// File: rtl/alu_md.sv
// Execute-stage ALU with valid/ready handshakes: base ops finish in one cycle,
// and RISC-V M-extension multiply/divide ops run as iterative radix-2 sequences.
module alu_md #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            zero,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic            accept;
    logic            is_mop;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    logic            sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;

    logic [2:0]      op_r;
    logic            neg_r;
    logic            bz_r;
    logic            fix;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] hi, lo, mcand;

    logic [XLEN:0]     add_sum, sh_rem, sub_diff;
    logic [XLEN-1:0]   hi_it, lo_it;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, md_res;

    assign is_mop    = (op[4:3] == 2'b10);
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);
    assign zero      = (res == '0);
    assign shamt     = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            5'b00000: alu_res = a & b;
            5'b00001: alu_res = a | b;
            5'b00010: alu_res = a + b;
            5'b00011: alu_res = a ^ b;
            5'b00100: alu_res = a << shamt;
            5'b00101: alu_res = a >> shamt;
            5'b01000: alu_res = $signed(a) >>> shamt;
            5'b00110: alu_res = a - b;
            5'b01100: alu_res = ~(a | b);
            5'b00111,
            5'b01111: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            5'b01110: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            default:  alu_res = '0;
        endcase
    end

    // Operand signedness: divides use op[0] (unsigned when set); multiplies vary per op.
    always_comb begin
        if (op[2]) begin
            sgn_a = !op[0];
            sgn_b = !op[0];
        end else begin
            sgn_a = (op[1:0] != 2'b11);
            sgn_b = !op[1];
        end
    end

    assign neg_a = sgn_a && a[XLEN-1];
    assign neg_b = sgn_b && b[XLEN-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    always_comb begin
        add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        sh_rem   = {hi, lo[XLEN-1]};
        sub_diff = sh_rem - {1'b0, mcand};
        if (op_r[2]) begin
            if (!sub_diff[XLEN]) begin
                hi_it = sub_diff[XLEN-1:0];
                lo_it = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_it = sh_rem[XLEN-1:0];
                lo_it = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_it = add_sum[XLEN:1];
            lo_it = {add_sum[0], lo[XLEN-1:1]};
        end
    end

    // Remainder by zero and signed overflow fall out of the magnitude math naturally;
    // only the quotient-by-zero needs an override.
    always_comb begin
        prod_fix = neg_r ? -{hi, lo} : {hi, lo};
        q_fix    = neg_r ? -lo : lo;
        r_fix    = neg_r ? -hi : hi;
        case (op_r)
            3'b000:                md_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:        md_res = bz_r ? '1 : q_fix;
            default:               md_res = r_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res   <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            op_r  <= '0;
            neg_r <= 1'b0;
            bz_r  <= 1'b0;
            fix   <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            if (is_mop) begin
                op_r  <= op[2:0];
                neg_r <= (op[2] && op[1]) ? neg_a : (neg_a ^ neg_b);
                bz_r  <= (b == '0);
                hi    <= '0;
                fix   <= 1'b0;
                cnt   <= SHW'(XLEN-1);
                if (op[2]) begin
                    lo    <= mag_a;
                    mcand <= mag_b;
                end else begin
                    lo    <= mag_b;
                    mcand <= mag_a;
                end
            end else begin
                res <= alu_res;
            end
        end else if (state == CALC) begin
            if (fix) begin
                res <= md_res;
            end else begin
                hi <= hi_it;
                lo <= lo_it;
                if (cnt == '0) begin
                    fix <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_mop ? CALC : DONE;
                end
            end
            CALC: begin
                if (fix) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nxt = is_mop ? CALC : DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: runs the same scenario set on a 32-bit and a 16-bit instance,
// with a result scoreboard fed at issue time and drained by a monitor.
module tb_alu_md;

    localparam logic [4:0] OP_AND = 5'b00000, OP_OR = 5'b00001, OP_ADD = 5'b00010, OP_XOR = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100, OP_SRL = 5'b00101, OP_SRA = 5'b01000, OP_SUB = 5'b00110;
    localparam logic [4:0] OP_NOR = 5'b01100, OP_SLT = 5'b00111, OP_SLT2 = 5'b01111, OP_SLTU = 5'b01110;
    localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010, OP_MULHU = 5'b10011;
    localparam logic [4:0] OP_DIV = 5'b10100, OP_DIVU = 5'b10101, OP_REM = 5'b10110, OP_REMU = 5'b10111;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp32;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_tb, sel, in_valid, out_ready;
    logic [4:0]  op;
    logic [31:0] a, b;

    logic        rst32, rst16, iv32, iv16;
    logic        ir32, ov32, z32, busy32;
    logic        ir16, ov16, z16, busy16;
    logic [31:0] r32;
    logic [15:0] r16;

    logic        ir_m, ov_m, z_m, busy_m;
    logic [31:0] res_m;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    assign rst32 = rst_tb | sel;
    assign rst16 = rst_tb | !sel;
    assign iv32  = in_valid & !sel;
    assign iv16  = in_valid & sel;
    assign ir_m   = sel ? ir16 : ir32;
    assign ov_m   = sel ? ov16 : ov32;
    assign z_m    = sel ? z16 : z32;
    assign busy_m = sel ? busy16 : busy32;
    assign res_m  = sel ? {16'h0000, r16} : r32;

    alu_md #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32), .op(op), .a(a), .b(b),
        .out_valid(ov32), .out_ready(out_ready), .res(r32), .zero(z32), .busy(busy32)
    );

    alu_md #(.XLEN(16)) u_dut16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .op(op), .a(a[15:0]), .b(b[15:0]),
        .out_valid(ov16), .out_ready(out_ready), .res(r16), .zero(z16), .busy(busy16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
        longint unsigned mask, ua, ub, r;
        longint sa, sb;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, x} & mask;
        ub = {32'd0, y} & mask;
        sa = ua[w-1] ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
        sb = ub[w-1] ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
        sh = int'(ub[4:0]) % w;
        case (o)
            OP_AND:           r = ua & ub;
            OP_OR:            r = ua | ub;
            OP_ADD:           r = ua + ub;
            OP_XOR:           r = ua ^ ub;
            OP_SLL:           r = ua << sh;
            OP_SRL:           r = ua >> sh;
            OP_SRA:           r = $unsigned(sa >>> sh);
            OP_SUB:           r = ua - ub;
            OP_NOR:           r = ~(ua | ub);
            OP_SLT, OP_SLT2:  r = (sa < sb) ? 64'd1 : 64'd0;
            OP_SLTU:          r = (ua < ub) ? 64'd1 : 64'd0;
            OP_MUL:           r = ua * ub;
            OP_MULH:          r = $unsigned((sa * sb) >>> w);
            OP_MULHSU:        r = $unsigned((sa * $signed(ub)) >>> w);
            OP_MULHU:         r = (ua * ub) >> w;
            OP_DIV:           r = (ub == 0) ? mask : $unsigned(sa / sb);
            OP_DIVU:          r = (ub == 0) ? mask : ua / ub;
            OP_REM:           r = (ub == 0) ? ua : $unsigned(sa % sb);
            OP_REMU:          r = (ub == 0) ? ua : ua % ub;
            default:          r = 64'd0;
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    function automatic void add(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.exp32 = e;
        tbl.push_back(v);
    endfunction

    // Results are taken on the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        logic [31:0] e;
        if (ov_m && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h with nothing pending (t=%0t)", res_m, $time);
            end else begin
                e = sb_q.pop_front();
                check("result", res_m, e);
                check("zero", 32'(z_m), 32'(e == 32'd0));
            end
        end
    end

    task automatic drive(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ir_m && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("accept_timeout", 32'(ir_m), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        sb_q.push_back(e);
        drive(o, x, y);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run_suite(input int w);
        int n, busy_n, ready_n, seen;
        logic [4:0] rops[20] = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SUB, OP_NOR, OP_SLT,
                                 OP_SLTU, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, 5'b11010};
        logic [4:0] ro;
        logic [31:0] rx, ry;

        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_tb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(ir_m), 32'd0);
        check("rst_out_valid", 32'(ov_m), 32'd0);
        check("rst_res", res_m, 32'd0);
        check("rst_zero", 32'(z_m), 32'd1);
        check("rst_busy", 32'(busy_m), 32'd0);
        rst_tb = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(ir_m), 32'd1);

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, (w == 32) ? tbl[i].exp32 : model(tbl[i].op, tbl[i].a, tbl[i].b, w));
        end
        drain();

        issue(OP_ADD, 32'h10, 32'h20, 32'h30);
        check("alu_latency", 32'(ov_m), 32'd1);
        check("alu_latency_res", res_m, 32'h30);
        drain();

        issue(OP_MULH, 32'h8000_8000, 32'h8000_8000, model(OP_MULH, 32'h8000_8000, 32'h8000_8000, w));
        n = 0; busy_n = 0; ready_n = 0;
        while (!ov_m && n < 200) begin
            if (busy_m) busy_n++;
            if (ir_m) ready_n++;
            @(posedge clk);
            #1;
            n++;
        end
        check("m_latency", 32'(n), 32'(w + 1));
        check("m_busy_cycles", 32'(busy_n), 32'(n));
        check("m_busy_done", 32'(busy_m), 32'd0);
        check("m_in_ready_calc", 32'(ready_n), 32'd0);
        drain();

        out_ready = 1'b0;
        issue(OP_MUL, 32'd6, 32'd7, 32'd42);
        n = 0;
        while (!ov_m && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid", 32'(ov_m), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_res_hold", res_m, 32'd42);
            check("bp_valid_hold", 32'(ov_m), 32'd1);
            check("bp_in_ready", 32'(ir_m), 32'd0);
        end
        out_ready = 1'b1;
        op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        sb_q.push_back(32'd3);
        @(negedge clk);
        check("b2b_in_ready", 32'(ir_m), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_valid", 32'(ov_m), 32'd1);
        check("b2b_res", res_m, 32'd3);
        drain();

        drive(OP_DIVU, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check("divu_busy", 32'(busy_m), 32'd1);
        rst_tb = 1'b1;
        #1;
        check("rst_mid_in_ready", 32'(ir_m), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_valid", 32'(ov_m), 32'd0);
        check("rst_mid_res", res_m, 32'd0);
        check("rst_mid_busy", 32'(busy_m), 32'd0);
        check("rst_mid_zero", 32'(z_m), 32'd1);
        rst_tb = 1'b0;
        #1;
        check("rst_mid_ready_after", 32'(ir_m), 32'd1);
        seen = 0;
        repeat (2 * w + 6) begin
            @(posedge clk);
            #1;
            if (ov_m) seen++;
        end
        check("no_stale", 32'(seen), 32'd0);

        for (int i = 0; i < 24; i++) begin
            ro = rops[$urandom_range(0, 19)];
            rx = $urandom;
            ry = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            issue(ro, rx, ry, model(ro, rx, ry, w));
        end
        drain();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; rst_tb = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;

        add(OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000);
        add(OP_SUB,    32'h00000005, 32'h00000005, 32'h00000000);
        add(OP_SRA,    32'h80000000, 32'h00000024, 32'hF8000000);
        add(OP_SRA,    32'hFFFF8000, 32'h00000024, 32'hFFFFF800);
        add(OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001);
        add(OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        add(OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        add(OP_OR,     32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0);
        add(OP_XOR,    32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
        add(OP_SLL,    32'h00000001, 32'h0000003F, 32'h80000000);
        add(OP_SRL,    32'h80000000, 32'h0000001F, 32'h00000001);
        add(OP_NOR,    32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000);
        add(OP_SLT2,   32'h00000001, 32'hFFFFFFFF, 32'h00000000);
        add(5'b01001,  32'h00000001, 32'h00000002, 32'h00000000);
        add(5'b11000,  32'h00000003, 32'h00000004, 32'h00000000);
        add(OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
        add(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        add(OP_MULH,   32'hFFFF8000, 32'hFFFF8000, 32'h00000000);
        add(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        add(OP_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);
        add(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        add(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        add(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        add(OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF);
        add(OP_REMU,   32'h00000005, 32'h00000000, 32'h00000005);
        add(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        add(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        add(OP_DIV,    32'hFFFF8000, 32'hFFFFFFFF, 32'h00008000);
        add(OP_REM,    32'hFFFF8000, 32'hFFFFFFFF, 32'h00000000);
        add(OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD);
        add(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001);
        add(OP_DIVU,   32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF);
        add(OP_REMU,   32'hFFFFFFFF, 32'h00000010, 32'h0000000F);
        add(OP_DIV,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF);
        add(OP_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB);

        run_suite(32);
        sel = 1'b1;
        run_suite(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
